// File: rtl/dpram_pkg.sv
// Shared types and default sizing for the dpram burst master and its response FIFO.
package dpram_pkg;

  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_RSP_DEPTH = 4;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  last;
  } rsp_entry_t;

endpackage

// File: rtl/dpram_rsp_fifo.sv
// Synchronous FIFO for read responses; head is visible the cycle after a push.
// Pushes when full and pops when empty are dropped, but the credit logic upstream keeps that from happening.
module dpram_rsp_fifo
  import dpram_pkg::*;
#(
  parameter int  DEPTH = DEF_RSP_DEPTH,
  parameter type T     = rsp_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The storage is not reset. The reset pointers and count make any stale contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dpram_burst_master.sv
// Turns burst commands into single-beat dpram transactions, with reads returned via a credited response FIFO.
// The read data path adds one register; defining DPRAM_MASTER_WCHECK_EN adds a sticky write-readback check on err.
module dpram_burst_master
  import dpram_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } entry_t;

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  state_t          state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0] beats;
  logic            inflight;
  logic            inflight_last;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  entry_t          head;
  entry_t          push_ent;
  logic [CW:0]     outstanding;
  logic            credit_ok;
  logic            mem_hs;
  logic            rsp_hs;
  logic            last_beat;

  // Count beats still in the memory pipe, not only those already queued, so the FIFO can never overflow.
  assign outstanding = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign credit_ok   = outstanding < (CW+1)'(RSP_DEPTH);

  always_comb begin
    mem_valid   = 1'b0;
    wdata_ready = 1'b0;
    mem_data    = '0;
    case (state)
      WRITE: begin
        mem_valid   = wdata_valid;
        wdata_ready = mem_ready;
        mem_data    = wdata;
      end
      READ:    mem_valid = credit_ok;
      default: mem_valid = 1'b0;
    endcase
  end

  assign mem_we    = (state == WRITE);
  assign mem_addr  = addr;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign mem_hs    = mem_valid && mem_ready;
  assign last_beat = (beats == (ADDR_W+1)'(1));

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = head.data;
  assign rsp_last  = head.last;
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign push_ent  = '{data: mem_q, last: inflight_last};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      beats         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          addr  <= cmd_addr;
          beats <= {1'b0, cmd_len} + 1'b1;
          state <= cmd_we ? WRITE : READ;
        end
        WRITE: if (mem_hs) begin
          addr  <= addr + 1'b1;
          beats <= beats - 1'b1;
          if (last_beat) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        READ: if (mem_hs) begin
          addr          <= addr + 1'b1;
          beats         <= beats - 1'b1;
          inflight      <= 1'b1;
          inflight_last <= last_beat;
          if (last_beat) state <= DRAIN;
        end
        DRAIN: if (rsp_hs && rsp_last) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dpram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (entry_t)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (push_ent),
    .pop       (rsp_hs),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef DPRAM_MASTER_WCHECK_EN
  logic              chk_pend;
  logic [DATA_W-1:0] chk_data;
  logic              err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_pend <= 1'b0;
      chk_data <= '0;
      err_q    <= 1'b0;
    end else begin
      chk_pend <= mem_hs && (state == WRITE);
      if (mem_hs && (state == WRITE)) chk_data <= wdata;
      if (chk_pend && (mem_q != chk_data)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_burst_master.sv
// Directed bench for dpram_burst_master, with a behavioural single-port memory behind the mem interface.
module tb_dpram_burst_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [5:0] cmd_addr, cmd_len;
  logic       wdata_valid, wdata_ready;
  logic [7:0] wdata;
  logic       mem_valid, mem_ready, mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_data, mem_q;
  logic       rsp_valid, rsp_ready, rsp_last;
  logic [7:0] rsp_data;
  logic       busy, done, err;

  always #5 clk = ~clk;

  dpram_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy), .done(done), .err(err)
  );

  // Memory model, write-through q, plus transaction logs
  logic [7:0] mem [64];
  logic [7:0] q_reg;
  logic       q_force_en;
  logic [7:0] q_force_val;
  logic [7:0] wsrc [256];
  assign mem_q = q_force_en ? q_force_val : q_reg;

  int cyc = 0, widx = 0, wr_n = 0, rd_n = 0, rsp_n = 0, done_n = 0, done_cyc = 0;
  logic [5:0] wr_addr_log [256];
  logic [7:0] wr_data_log [256];
  int         wr_cyc_log  [256];
  logic [5:0] rd_addr_log [256];
  int         rd_cyc_log  [256];
  logic [7:0] rsp_data_log [256];
  logic       rsp_last_log [256];
  int         rsp_cyc_log  [256];

  assign wdata = wsrc[widx[7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_valid && mem_ready) begin
      if (mem_we) begin
        mem[mem_addr]     <= mem_data;
        q_reg             <= mem_data;
        wr_addr_log[wr_n] <= mem_addr;
        wr_data_log[wr_n] <= mem_data;
        wr_cyc_log[wr_n]  <= cyc;
        wr_n              <= wr_n + 1;
      end else begin
        q_reg             <= mem[mem_addr];
        rd_addr_log[rd_n] <= mem_addr;
        rd_cyc_log[rd_n]  <= cyc;
        rd_n              <= rd_n + 1;
      end
    end
    if (wdata_valid && wdata_ready) widx <= widx + 1;
    if (rsp_valid && rsp_ready) begin
      rsp_data_log[rsp_n] <= rsp_data;
      rsp_last_log[rsp_n] <= rsp_last;
      rsp_cyc_log[rsp_n]  <= cyc;
      rsp_n               <= rsp_n + 1;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_cmd(input logic we, input logic [5:0] a, input logic [5:0] l);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int bw, br, bp, bd, issued, popped;
  logic exp_mv;
  logic [31:0] exp_err;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; mem_ready = 1'b1; rsp_ready = 1'b0;
    q_force_en = 1'b0; q_force_val = '0;
    tick(2);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_mem_valid", 32'(mem_valid), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wdata_ready", 32'(wdata_ready), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    tick(1);

    // Write burst that wraps at the top of the address space
    bw = wr_n; bd = done_n;
    for (int i = 0; i < 4; i++) wsrc[(widx + i) % 256] = 8'hA0 + 8'(i);
    wdata_valid = 1'b1;
    send_cmd(1'b1, 6'h3E, 6'd3);
    check("t1_busy", 32'(busy), 1);
    wait_idle("t1");
    wdata_valid = 1'b0;
    tick(3);
    check("t1_nwr", 32'(wr_n - bw), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", 32'(wr_addr_log[bw + i]), 32'((6'h3E + i) % 64));
      check("t1_data", 32'(wr_data_log[bw + i]), 32'(8'hA0 + i));
    end
    check("t1_done_n", 32'(done_n - bd), 1);
    check("t1_done_cyc", 32'(done_cyc), 32'(wr_cyc_log[bw + 3] + 1));

    // Read it back at full throughput
    rsp_ready = 1'b1;
    br = rd_n; bp = rsp_n; bd = done_n;
    send_cmd(1'b0, 6'h3E, 6'd3);
    wait_idle("t2");
    tick(2);
    check("t2_nrsp", 32'(rsp_n - bp), 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_data", 32'(rsp_data_log[bp + i]), 32'(8'hA0 + i));
      check("t2_last", 32'(rsp_last_log[bp + i]), 32'(i == 3));
      check("t2_cyc", 32'(rsp_cyc_log[bp + i]), 32'(rsp_cyc_log[bp] + i));
    end
    check("t2_latency", 32'(rsp_cyc_log[bp] - rd_cyc_log[br]), 2);
    check("t2_done_n", 32'(done_n - bd), 1);

    // Full-space write from 0x10; a command offered mid-burst must be ignored
    bw = wr_n; br = rd_n;
    for (int i = 0; i < 64; i++) wsrc[(widx + i) % 256] = pat(i);
    wdata_valid = 1'b1;
    send_cmd(1'b1, 6'h10, 6'h3F);
    tick(3);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 6'h00; cmd_len = 6'h00;
    for (int i = 0; i < 3; i++) begin
      check("t5_cmd_ready_busy", 32'(cmd_ready), 0);
      tick(1);
    end
    cmd_valid = 1'b0;
    wait_idle("t5w");
    wdata_valid = 1'b0;
    tick(2);
    check("t5_nwr", 32'(wr_n - bw), 64);
    check("t5_no_stray_read", 32'(rd_n - br), 0);
    for (int i = 0; i < 64; i++) begin
      check("t5_waddr", 32'(wr_addr_log[bw + i]), 32'((16 + i) % 64));
      check("t5_wdata", 32'(wr_data_log[bw + i]), 32'(pat(i)));
    end
    br = rd_n; bp = rsp_n;
    send_cmd(1'b0, 6'h10, 6'h3F);
    wait_idle("t5r");
    tick(2);
    check("t5_nrd", 32'(rd_n - br), 64);
    check("t5_nrsp", 32'(rsp_n - bp), 64);
    for (int i = 0; i < 64; i++) begin
      check("t5_raddr", 32'(rd_addr_log[br + i]), 32'((16 + i) % 64));
      check("t5_rdata", 32'(rsp_data_log[bp + i]), 32'(pat(i)));
      check("t5_rlast", 32'(rsp_last_log[bp + i]), 32'(i == 63));
    end

    // Backpressured read: credits must throttle mem_valid
    br = rd_n; bp = rsp_n;
    send_cmd(1'b0, 6'h00, 6'd7);
    for (int n = 0; n < 200 && busy; n++) begin
      mem_ready = !(n == 1 || n == 2);
      rsp_ready = (n % 2 == 0);
      issued = rd_n - br;
      popped = rsp_n - bp;
      exp_mv = (issued < 8) && (issued - popped < 4);
      check("t3_mem_valid", 32'(mem_valid), 32'(exp_mv));
      @(negedge clk);
    end
    check("t3_timeout", 32'(busy), 0);
    mem_ready = 1'b1; rsp_ready = 1'b1;
    check("t3_nrsp", 32'(rsp_n - bp), 8);
    for (int i = 0; i < 8; i++) begin
      check("t3_data", 32'(rsp_data_log[bp + i]), 32'(pat(i + 48)));
      check("t3_last", 32'(rsp_last_log[bp + i]), 32'(i == 7));
    end

    // Reset in the middle of a write burst
    bw = wr_n;
    for (int i = 0; i < 8; i++) wsrc[(widx + i) % 256] = 8'hC0 + 8'(i);
    wdata_valid = 1'b1;
    send_cmd(1'b1, 6'h20, 6'd7);
    for (int n = 0; n < 20 && (wr_n - bw) < 2; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_mem_valid_rst", 32'(mem_valid), 0);
    check("t4_busy_rst", 32'(busy), 0);
    tick(1);
    rst_n = 1'b1;
    wdata_valid = 1'b0;
    tick(1);
    check("t4_cmd_ready", 32'(cmd_ready), 1);
    check("t4_nwr", 32'(wr_n - bw), 2);
    bp = rsp_n;
    send_cmd(1'b0, 6'h20, 6'd1);
    wait_idle("t4r");
    tick(2);
    check("t4_nrsp", 32'(rsp_n - bp), 2);
    check("t4_rd0", 32'(rsp_data_log[bp]), 32'h0C0);
    check("t4_rd1", 32'(rsp_data_log[bp + 1]), 32'h0C1);
    check("t4_wr_total", 32'(wr_n - bw), 2);

    // Write readback check against a corrupted q
    check("t6_err_before", 32'(err), 0);
    q_force_en = 1'b1; q_force_val = 8'hFF;
    wsrc[widx % 256] = 8'h55;
    wdata_valid = 1'b1;
    send_cmd(1'b1, 6'h05, 6'd0);
    wait_idle("t6");
    wdata_valid = 1'b0;
    tick(3);
    q_force_en = 1'b0;
`ifdef DPRAM_MASTER_WCHECK_EN
    exp_err = 32'd1;
`else
    exp_err = 32'd0;
`endif
    check("t6_err", 32'(err), exp_err);
    tick(4);
    check("t6_err_sticky", 32'(err), exp_err);
    rst_n = 1'b0;
    tick(1);
    check("t6_err_reset", 32'(err), 0);
    rst_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpram_burst_master.md
Name: dpram_burst_master

Overview:
- Initiator for one dpram port. Converts burst commands (start address, length, read/write) into single-beat valid/ready memory transactions.
- Streams write data in from an upstream source. Returns read data on a backpressured response channel.
- Sits between a DMA/test sequencer and port A or B of the dual-port RAM.

Parameters:
ADDR_W, 6, memory address width; burst addresses wrap modulo 2**ADDR_W
DATA_W, 8, data width of write stream, memory and response
RSP_DEPTH, 4, response FIFO entries (power of 2, >=3 for full read throughput)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  burst command offered
cmd_ready  output  1  block idle; command accepted on cmd_valid&cmd_ready
cmd_we  input  1  1 = write burst, 0 = read burst
cmd_addr  input  ADDR_W  start address
cmd_len  input  ADDR_W  beats minus 1 (0 = 1 beat, all-ones = 2**ADDR_W beats)
wdata_valid  input  1  write beat offered
wdata_ready  output  1  write beat consumed
wdata  input  DATA_W  write beat data
mem_valid  output  1  to dpram valid
mem_ready  input  1  from dpram ready
mem_we  output  1  to dpram we
mem_addr  output  ADDR_W  to dpram addr
mem_data  output  DATA_W  to dpram data
mem_q  input  DATA_W  from dpram q; valid the cycle after a handshake
rsp_valid  output  1  read beat available
rsp_ready  input  1  downstream accepts read beat
rsp_data  output  DATA_W  read beat data
rsp_last  output  1  marks final beat of read burst
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at burst completion
err  output  1  sticky write-check error (optional feature)

Behaviour:
- Reset (async, rst_n low): state IDLE; addr and beat counters, inflight flag and FIFO cleared. Outputs 0 except cmd_ready=1. Any in-progress burst is abandoned; no further mem_valid.
- Handshake rule everywhere: transfer on valid&ready at the rising edge. Valid, once raised, is held with stable payload until accepted.
- FSM states IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. On cmd handshake, latch addr, beats=cmd_len+1 and we. Go to WRITE or READ. First mem_valid appears the cycle after acceptance.
- WRITE:
  - mem_we=1, mem_addr=current addr, mem_data=wdata.
  - mem_valid=wdata_valid and wdata_ready=mem_ready. Both are combinational, so one write beat equals one mem handshake.
  - Each handshake: addr+1 (wraps 2**ADDR_W-1 -> 0), beat count-1.
  - Last beat -> IDLE; done=1 in the following cycle.
- READ:
  - mem_we=0; mem_valid=1 while credits are available: fifo_count+inflight < RSP_DEPTH.
  - Each mem handshake sets inflight. mem_q is pushed into the FIFO at the next edge, tagged last if it was the final beat.
  - After the last issue -> DRAIN.
- DRAIN: mem_valid=0. When the last beat has been popped (rsp handshake with rsp_last=1) -> IDLE; done=1 that following cycle.
- Read latency: mem handshake at edge k -> rsp_valid from edge k+1 at earliest. Full throughput (1 beat/cycle) with rsp_ready held 1.
- Response FIFO: simultaneous push and pop leave count unchanged. Never overflows, guaranteed by credits. rsp_data/rsp_last come from the FIFO head.
- Commands are never accepted outside IDLE. cmd_len all-ones issues exactly 2**ADDR_W beats and touches every address once.
- wdata offered in IDLE/READ/DRAIN is ignored; wdata_ready=0.

Optional Feature:
DPRAM_MASTER_WCHECK_EN
- Defined: in the cycle after each write handshake, compare mem_q with the registered written data. On mismatch, set err. err stays set until reset.
- Undefined: err tied 0, compare logic absent.

Decomposition:
- dpram_pkg: state enum (IDLE, WRITE, READ, DRAIN), default ADDR_W/DATA_W, RSP_DEPTH constant, response entry struct {data, last}.
- Sub-module dpram_rsp_fifo: synchronous FIFO with count output, async active-low reset.

Test Plan:
- Write burst addr=0x3E, len=3, data A0..A3 -> mem writes at 0x3E,0x3F,0x00,0x01; done pulses once, one cycle after the last handshake.
- Read burst addr=0x3E, len=3, rsp_ready=1 -> rsp_data A0,A1,A2,A3 on consecutive cycles; rsp_last only on A3; first rsp_valid 2 edges after first mem handshake.
- Read len=7 with rsp_ready toggling 1010 and mem_ready low 2 cycles -> mem_valid stalls when fifo_count+inflight=4, no beat lost or duplicated, order preserved.
- Assert rst_n low mid write burst (beat 2 of 8) -> mem_valid=0 immediately, cmd_ready=1 after release, next command runs normally.
- len=0x3F write then read from 0x10 -> all 64 addresses; cmd_valid during busy not accepted.
- WCHECK_EN: force mem_q=0xFF after writing 0x55 -> err=1 and stays 1 until reset; without the macro err=0.
